// File: rtl/sprite_motion_sequencer_if.sv
// Bundle between the sprite motion sequencer and its neighbours:
// the frame tick and size come in, the renderer read port goes out.
interface sprite_motion_sequencer_if;
    logic       frame_tick;
    logic       freeze;
    logic [8:0] size;
    logic [2:0] rd_idx;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       busy;
    logic       pass_done;
    logic       overrun;

    modport master (
        output frame_tick, freeze, size, rd_idx,
        input  rd_x, rd_y, busy, pass_done, overrun
    );

    modport slave (
        input  frame_tick, freeze, size, rd_idx,
        output rd_x, rd_y, busy, pass_done, overrun
    );
endinterface

// File: rtl/sprite_motion_sequencer.sv
// Once-per-frame motion update for five bouncing squares: one shared
// step unit walks x then y of each sprite, then the results are committed atomically.
module sprite_motion_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MAX_SIZE = 240
) (
    input logic                       clk,
    input logic                       rst_n,
    sprite_motion_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [9:0] limX_q, limX_d;
    logic [9:0] limY_q, limY_d;
    logic       overrun_q, overrun_d;

    logic [9:0] workX_q [0:4];
    logic [9:0] workY_q [0:4];
    logic [4:0] dirX_q;
    logic [4:0] dirY_q;
    logic [9:0] dispX_q [0:4];
    logic [9:0] dispY_q [0:4];
    logic [9:0] rdX_q, rdY_q;

    logic [9:0]  sizeSat;
    logic        onX;
    logic        curDir;
    logic [9:0]  curPos;
    logic [9:0]  speed;
    logic [9:0]  lim;
    logic [10:0] sum;
    logic [9:0]  stepPos;
    logic        stepDir;

    function automatic logic [9:0] resetX(input logic [2:0] i);
        case (i)
            3'd1:    resetX = 10'd120;
            3'd2:    resetX = 10'd100;
            3'd3:    resetX = 10'd40;
            3'd4:    resetX = 10'd40;
            default: resetX = 10'd0;
        endcase
    endfunction

    function automatic logic [9:0] resetY(input logic [2:0] i);
        case (i)
            3'd0:    resetY = 10'd300;
            3'd1:    resetY = 10'd300;
            3'd2:    resetY = 10'd400;
            3'd3:    resetY = 10'd200;
            3'd4:    resetY = 10'd50;
            default: resetY = 10'd0;
        endcase
    endfunction

    localparam logic [4:0] RESET_DIR_X = 5'b01110;
    localparam logic [4:0] RESET_DIR_Y = 5'b11101;

    always_comb begin
        sizeSat = (bus.size > 9'(MAX_SIZE)) ? 10'(MAX_SIZE) : {1'b0, bus.size};
    end

    // FSM: IDLE waits for an accepted tick, then X/Y alternate per sprite, then COMMIT
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        limX_d    = limX_q;
        limY_d    = limY_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (bus.frame_tick && !bus.freeze) begin
                    state_d = STEP_X;
                    idx_d   = 3'd0;
                    limX_d  = 10'(H_ACTIVE) - sizeSat;
                    limY_d  = 10'(V_ACTIVE) - sizeSat;
                end
            end
            STEP_X: state_d = STEP_Y;
            STEP_Y: begin
                if (idx_q == 3'd4) begin
                    state_d = COMMIT;
                end else begin
                    state_d = STEP_X;
                    idx_d   = idx_q + 3'd1;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && bus.frame_tick) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            limX_q    <= 10'(H_ACTIVE);
            limY_q    <= 10'(V_ACTIVE);
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            limX_q    <= limX_d;
            limY_q    <= limY_d;
            overrun_q <= overrun_d;
        end
    end

    // Shared step unit: the current axis selects position, direction, speed and wall
    always_comb begin
        onX    = (state_q == STEP_X);
        curPos = onX ? workX_q[idx_q] : workY_q[idx_q];
        curDir = onX ? dirX_q[idx_q] : dirY_q[idx_q];
        lim    = onX ? limX_q : limY_q;
        case ({onX, curDir})
            2'b11:   speed = 10'd7 + {7'd0, idx_q};
            2'b10:   speed = 10'd3 + {7'd0, idx_q};
            2'b01:   speed = 10'd6 + {7'd0, idx_q};
            default: speed = 10'd10 + {7'd0, idx_q};
        endcase
        sum     = {1'b0, curPos} + {1'b0, speed};
        stepPos = curPos;
        stepDir = curDir;
        if (curDir) begin
            if (sum >= {1'b0, lim}) begin
                stepPos = lim;
                stepDir = 1'b0;
            end else begin
                stepPos = sum[9:0];
            end
        end else begin
            if (curPos <= speed) begin
                stepPos = 10'd0;
                stepDir = 1'b1;
            end else begin
                stepPos = curPos - speed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                workX_q[i] <= resetX(3'(i));
                workY_q[i] <= resetY(3'(i));
                dispX_q[i] <= resetX(3'(i));
                dispY_q[i] <= resetY(3'(i));
            end
            dirX_q <= RESET_DIR_X;
            dirY_q <= RESET_DIR_Y;
        end else begin
            case (state_q)
                STEP_X: begin
                    workX_q[idx_q] <= stepPos;
                    dirX_q[idx_q]  <= stepDir;
                end
                STEP_Y: begin
                    workY_q[idx_q] <= stepPos;
                    dirY_q[idx_q]  <= stepDir;
                end
                COMMIT: begin
                    for (int i = 0; i < 5; i++) begin
                        dispX_q[i] <= workX_q[i];
                        dispY_q[i] <= workY_q[i];
                    end
                end
                default: ;
            endcase
        end
    end

    // During COMMIT the display bank is still old, so read the work bank to show new values from t+12
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdX_q <= 10'd0;
            rdY_q <= 10'd0;
        end else if (bus.rd_idx > 3'd4) begin
            rdX_q <= 10'd0;
            rdY_q <= 10'd0;
        end else if (state_q == COMMIT) begin
            rdX_q <= workX_q[bus.rd_idx];
            rdY_q <= workY_q[bus.rd_idx];
        end else begin
            rdX_q <= dispX_q[bus.rd_idx];
            rdY_q <= dispY_q[bus.rd_idx];
        end
    end

    assign bus.rd_x      = rdX_q;
    assign bus.rd_y      = rdY_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.pass_done = (state_q == COMMIT);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sprite_motion_sequencer.sv
// Self-checking bench for sprite_motion_sequencer: constant tables, timed corner
// sequences and randomized frames against a whole-pass behavioural model.
module tb_sprite_motion_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sprite_motion_sequencer_if bus();

    sprite_motion_sequencer #(
        .H_ACTIVE(640),
        .V_ACTIVE(480),
        .MAX_SIZE(240)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int idx;
        int expX;
        int expY;
    } vec_t;

    vec_t resetTab [8];
    vec_t passTab  [8];
    int   wallExp  [7];

    int vectors     = 0;
    int miscompares = 0;

    int mX [5];
    int mY [5];
    int mDx[5];
    int mDy[5];
    int dX [5];
    int dY [5];
    int mOverrun;

    // Reference model: a whole frame pass computed straight from the motion rules
    function automatic void stepAxis(inout int p, inout int d, input int up, input int down, input int lim);
        if (d == 1) begin
            if (p + up >= lim) begin
                p = lim;
                d = 0;
            end else begin
                p = p + up;
            end
        end else begin
            if (p <= down) begin
                p = 0;
                d = 1;
            end else begin
                p = p - down;
            end
        end
    endfunction

    function automatic void modelReset();
        mX  = '{0, 120, 100, 40, 40};
        mY  = '{300, 300, 400, 200, 50};
        mDx = '{0, 1, 1, 1, 0};
        mDy = '{1, 0, 1, 1, 1};
        dX  = mX;
        dY  = mY;
        mOverrun = 0;
    endfunction

    function automatic void modelPass(input int sz);
        int s;
        int p;
        int d;
        s = (sz > 240) ? 240 : sz;
        for (int i = 0; i < 5; i++) begin
            p = mX[i]; d = mDx[i];
            stepAxis(p, d, 7 + i, 3 + i, 640 - s);
            mX[i] = p; mDx[i] = d;
            p = mY[i]; d = mDy[i];
            stepAxis(p, d, 6 + i, 10 + i, 480 - s);
            mY[i] = p; mDy[i] = d;
        end
        dX = mX;
        dY = mY;
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit tick, input bit frz, input int sz);
        bus.frame_tick = tick;
        bus.freeze     = frz;
        bus.size       = sz[8:0];
        stepCycle();
        bus.frame_tick = 1'b0;
        bus.freeze     = 1'b0;
    endtask

    task automatic doReset();
        bus.frame_tick = 1'b0;
        bus.freeze     = 1'b0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        stepCycle();
    endtask

    task automatic runPass(input int sz);
        applyStimulus(1'b1, 1'b0, sz);
        modelPass(sz);
        repeat (11) stepCycle();
    endtask

    task automatic sweepDisplay(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.rd_idx = 3'(i);
            stepCycle();
            checkOutput({tag, " rd_x"}, bus.rd_x, (i < 5) ? dX[i] : 0);
            checkOutput({tag, " rd_y"}, bus.rd_y, (i < 5) ? dY[i] : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int spur;
        int sz;
        bit frz;

        resetTab[0] = '{0, 0, 300};   resetTab[1] = '{1, 120, 300};
        resetTab[2] = '{2, 100, 400}; resetTab[3] = '{3, 40, 200};
        resetTab[4] = '{4, 40, 50};   resetTab[5] = '{5, 0, 0};
        resetTab[6] = '{6, 0, 0};     resetTab[7] = '{7, 0, 0};
        passTab[0]  = '{0, 0, 306};   passTab[1]  = '{1, 128, 289};
        passTab[2]  = '{2, 109, 400}; passTab[3]  = '{3, 50, 209};
        passTab[4]  = '{4, 33, 60};   passTab[5]  = '{5, 0, 0};
        passTab[6]  = '{6, 0, 0};     passTab[7]  = '{7, 0, 0};
        wallExp     = '{33, 26, 19, 12, 5, 0, 11};

        bus.rd_idx = 3'd0;
        bus.size   = 9'd80;
        doReset();

        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset pass_done", bus.pass_done, 0);
        checkOutput("reset overrun", bus.overrun, 0);
        foreach (resetTab[k]) begin
            bus.rd_idx = 3'(resetTab[k].idx);
            stepCycle();
            checkOutput("reset table rd_x", bus.rd_x, resetTab[k].expX);
            checkOutput("reset table rd_y", bus.rd_y, resetTab[k].expY);
        end

        // First pass with size 80: busy window, commit pulse, atomic display update
        bus.rd_idx = 3'd1;
        stepCycle();
        applyStimulus(1'b1, 1'b0, 80);
        for (int k = 1; k <= 11; k++) begin
            checkOutput("pass busy window", bus.busy, 1);
            checkOutput("pass pass_done timing", bus.pass_done, (k == 11) ? 1 : 0);
            if (k == 11) checkOutput("display held before commit", bus.rd_x, 120);
            stepCycle();
        end
        checkOutput("busy after pass", bus.busy, 0);
        checkOutput("pass_done after pass", bus.pass_done, 0);
        checkOutput("display new at t+12", bus.rd_x, 128);
        modelPass(80);
        foreach (passTab[k]) begin
            bus.rd_idx = 3'(passTab[k].idx);
            stepCycle();
            checkOutput("pass table rd_x", bus.rd_x, passTab[k].expX);
            checkOutput("pass table rd_y", bus.rd_y, passTab[k].expY);
        end
        sweepDisplay("pass model");

        // Size saturation at 240
        doReset();
        runPass(300);
        bus.rd_idx = 3'd2; stepCycle();
        checkOutput("saturate sprite2 y", bus.rd_y, 240);
        bus.rd_idx = 3'd0; stepCycle();
        checkOutput("saturate sprite0 y", bus.rd_y, 240);
        runPass(300);
        bus.rd_idx = 3'd2; stepCycle();
        checkOutput("saturate sprite2 y second", bus.rd_y, 228);
        sweepDisplay("saturate model");

        // Left wall bounce of sprite 4
        doReset();
        bus.rd_idx = 3'd4; stepCycle();
        checkOutput("wall start x", bus.rd_x, 40);
        foreach (wallExp[k]) begin
            runPass(80);
            bus.rd_idx = 3'd4; stepCycle();
            checkOutput("wall sprite4 x", bus.rd_x, wallExp[k]);
        end

        // Tick during a pass sets overrun but the pass still completes on time
        doReset();
        applyStimulus(1'b1, 1'b0, 80);
        repeat (3) stepCycle();
        bus.frame_tick = 1'b1;
        stepCycle();
        bus.frame_tick = 1'b0;
        checkOutput("overrun set", bus.overrun, 1);
        repeat (6) stepCycle();
        checkOutput("overrun pass_done t+11", bus.pass_done, 1);
        stepCycle();
        checkOutput("overrun busy t+12", bus.busy, 0);
        modelPass(80);
        applyStimulus(1'b1, 1'b1, 80);
        checkOutput("freeze no busy", bus.busy, 0);
        checkOutput("freeze overrun held", bus.overrun, 1);
        stepCycle();
        checkOutput("freeze no busy later", bus.busy, 0);
        sweepDisplay("overrun model");

        // Asynchronous reset in the middle of a pass
        bus.rd_idx = 3'd1;
        stepCycle();
        applyStimulus(1'b1, 1'b0, 80);
        repeat (4) stepCycle();
        checkOutput("midpass busy before reset", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", bus.busy, 0);
        checkOutput("async reset pass_done", bus.pass_done, 0);
        checkOutput("async reset overrun", bus.overrun, 0);
        checkOutput("async reset rd_x", bus.rd_x, 0);
        checkOutput("async reset rd_y", bus.rd_y, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        stepCycle();
        sweepDisplay("after reset");

        // Randomized frames with random freeze, size and in-pass spurious ticks
        doReset();
        for (int n = 0; n < 40; n++) begin
            sz  = int'($urandom_range(0, 511));
            frz = ($urandom_range(0, 3) == 0);
            applyStimulus(1'b1, frz, sz);
            if (frz) begin
                checkOutput("random freeze busy", bus.busy, 0);
            end else begin
                modelPass(sz);
                spur = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 11)) : 0;
                for (int k = 1; k <= 11; k++) begin
                    bus.frame_tick = (k == spur);
                    stepCycle();
                end
                bus.frame_tick = 1'b0;
                if (spur != 0) mOverrun = 1;
                checkOutput("random busy end", bus.busy, 0);
            end
            checkOutput("random overrun", bus.overrun, mOverrun);
            sweepDisplay("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
